// File: rtl/led_matrix_driver_pkg.sv
// Shared constants, command encoding and cell-index helpers for the 3x3 LED matrix driver.
// Cell numbering matches the keypad key code: pos = 3*row + col.
package led_pkg;

  localparam int NUM_ROWS  = 3;
  localparam int NUM_COLS  = 3;
  localparam int NUM_CELLS = 9;
  localparam int POS_W     = 4;

  typedef enum logic [1:0] {
    OP_SET    = 2'b00,
    OP_CLR    = 2'b01,
    OP_TGL    = 2'b10,
    OP_CLRALL = 2'b11
  } wr_op_e;

  typedef logic [NUM_CELLS-1:0] pattern_t;

  function automatic logic [POS_W-1:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
    return POS_W'(r) * POS_W'(NUM_COLS) + POS_W'(c);
  endfunction

  function automatic logic pos_valid(input logic [POS_W-1:0] pos);
    return pos < POS_W'(NUM_CELLS);
  endfunction

endpackage

// File: rtl/led_matrix_driver_if.sv
// Command port between the game logic (master) and the LED matrix driver (slave).
// The slave reports the live lamp pattern and a rejected-command pulse back.
interface led_matrix_driver_if;
  import led_pkg::*;

  logic             wr_en;
  wr_op_e           wr_op;
  logic [POS_W-1:0] wr_pos;
  pattern_t         pattern;
  logic             wr_err;

  modport master (
    output wr_en, wr_op, wr_pos,
    input  pattern, wr_err
  );

  modport slave (
    input  wr_en, wr_op, wr_pos,
    output pattern, wr_err
  );

endinterface

// File: rtl/led_matrix_driver_scan_timer.sv
// Column-slot timebase: prescaler over SCAN_DIV clocks, slot counter 0..2, and a
// one-cycle frame_start pulse in the cycle after the last slot wraps back to 0.
module scan_timer
  import led_pkg::*;
#(
  parameter  int SCAN_DIV = 16666,
  localparam int QW       = $clog2(SCAN_DIV)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [QW-1:0] prescale,
  output logic [1:0]    slot,
  output logic          frame_start
);

  localparam logic [QW-1:0] PRESCALE_LAST = QW'(SCAN_DIV - 1);
  localparam logic [1:0]    SLOT_LAST     = 2'(NUM_COLS - 1);

  logic wrap;

  assign wrap = (prescale == PRESCALE_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale    <= '0;
      slot        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap && (slot == SLOT_LAST);
      if (wrap) begin
        prescale <= '0;
        slot     <= (slot == SLOT_LAST) ? 2'd0 : slot + 2'd1;
      end else begin
        prescale <= prescale + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_matrix_driver.sv
// 3x3 LED matrix driver: lamp pattern register with set/clear/toggle/clear-all commands,
// column-multiplexed onto active-low columns and active-high rows with blanking and blink.
module led_matrix_driver
  import led_pkg::*;
#(
  parameter int SCAN_DIV     = 16666,
  parameter int BLANK_CYC    = 64,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                clk,
  input  logic                reset,
  led_matrix_driver_if.slave  cmd,
  input  logic                blink_en,
  output logic [NUM_COLS-1:0] column,
  output logic [NUM_ROWS-1:0] row,
  output logic                frame_start
);

  localparam int QW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [QW-1:0] BLANK_END  = QW'(BLANK_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [QW-1:0]       prescale;
  logic [1:0]          slot;
  pattern_t            pattern_q;
  pattern_t            pattern_next;
  logic                err_q;
  logic                err_next;
  logic [BW-1:0]       blink_cnt;
  logic                phase;
  logic                blank;
  logic                lamp_on;
  logic [NUM_COLS-1:0] column_next;
  logic [NUM_ROWS-1:0] row_next;

  scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clk         (clk),
    .reset       (reset),
    .prescale    (prescale),
    .slot        (slot),
    .frame_start (frame_start)
  );

  assign cmd.pattern = pattern_q;
  assign cmd.wr_err  = err_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value held and infer a latch.
  always_comb begin
    pattern_next = pattern_q;
    err_next     = 1'b0;
    if (cmd.wr_en) begin
      if (cmd.wr_op == OP_CLRALL) begin
        pattern_next = '0;
      end else if (!pos_valid(cmd.wr_pos)) begin
        err_next = 1'b1;
      end else begin
        case (cmd.wr_op)
          OP_SET:  pattern_next[cmd.wr_pos] = 1'b1;
          OP_CLR:  pattern_next[cmd.wr_pos] = 1'b0;
          OP_TGL:  pattern_next[cmd.wr_pos] = ~pattern_q[cmd.wr_pos];
          default: pattern_next = pattern_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_next;
      err_q     <= err_next;
    end
  end

  // With blink disabled the counter parks at 0 and phase at 1, so re-enabling
  // always gives a full BLINK_FRAMES lit period before the first dark one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (!blink_en) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    blank       = (prescale < BLANK_END);
    lamp_on     = phase || !blink_en;
    column_next = blank ? '1 : ~(3'b001 << slot);
    row_next    = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      row_next[r] = !blank && pattern_q[cell_idx(2'(r), slot)] && lamp_on;
    end
  end

  // Drive pins straight from flops so the strobes are glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      column <= '1;
      row    <= '0;
    end else begin
      column <= column_next;
      row    <= row_next;
    end
  end

endmodule
